// File: rtl/vu_level_meter.sv
// vu_level_meter: peak-hold / decay VU meter fed one audio sample per
// received byte on the clkx16 domain. Drives a thermometer LED bar, a clip
// lamp and a saturating count of receiver framing-error rising edges.
//
// Optional build macro: OFFSET_BINARY_EN
//   defined   -> samples are offset binary (0x80 = silence, clip on 0x00/0xFF)
//   undefined -> samples are two's complement (clip on 0x7F/0x80)
//
// LEDS must be a power of two in 2..128; segment i lights when peak > i*STEP.
module vu_level_meter #(
   parameter int LEDS         = 8,
   parameter int CNT_W        = 20,
   parameter int HOLD_CYCLES  = 921600,
   parameter int DECAY_CYCLES = 14400
) (
   input  logic            clkx16,
   input  logic            reset,
   input  logic [7:0]      data,
   input  logic            load,
   input  logic            error,
   output logic [LEDS-1:0] level,
   output logic [6:0]      peak,
   output logic            clip,
   output logic [7:0]      err_cnt
);

   localparam int STEP = 128 / LEDS;
   localparam logic [CNT_W-1:0] C_HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_DECAY_LOAD = CNT_W'(DECAY_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HOLD  = 2'd1,
      S_DECAY = 2'd2
   } state_t;

   state_t           r_state;
   logic [6:0]       r_peak;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [CNT_W-1:0] r_decay_cnt;
   logic             r_clip;
   logic [LEDS-1:0]  r_level;
   logic [7:0]       r_err_cnt;
   logic             r_err_d;

   logic [7:0]       w_abs;
   logic [6:0]       w_mag;
   logic             w_is_clip;
   logic             w_update;
   logic             w_refresh;
   logic             w_take;
   logic             w_hold_expire;
   logic [LEDS-1:0]  w_level_next;

   // Sample magnitude and clip detection straight from the input byte.
   always_comb begin
`ifdef OFFSET_BINARY_EN
      // Distance from the 0x80 midpoint; 0x00 gives 128 and is saturated below.
      w_abs     = data[7] ? (data - 8'd128) : (8'd128 - data);
      w_is_clip = (data == 8'h00) || (data == 8'hFF);
`else
      // Two's complement absolute value; 0x80 gives 128 and is saturated below.
      w_abs     = data[7] ? (8'd0 - data) : data;
      w_is_clip = (data == 8'h7F) || (data == 8'h80);
`endif
      w_mag = w_abs[7] ? 7'd127 : w_abs[6:0];
   end

   // A qualifying load (new maximum, or a non-zero equal value) always beats
   // whatever the hold/decay timers would have done in the same cycle.
   assign w_update      = load && (w_mag > r_peak);
   assign w_refresh     = load && (w_mag == r_peak) && (r_peak != 7'd0);
   assign w_take        = w_update || w_refresh;
   assign w_hold_expire = !w_take && (r_state == S_HOLD) && (r_hold_cnt == '0);

   // Peak envelope state machine with hold timer, decay timer and clip lamp.
   always_ff @(posedge clkx16 or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_peak      <= 7'd0;
         r_hold_cnt  <= '0;
         r_decay_cnt <= '0;
         r_clip      <= 1'b0;
      end else begin
         if (w_take) begin
            if (w_update) begin
               r_peak <= w_mag;
            end
            r_hold_cnt <= C_HOLD_LOAD;
            r_state    <= S_HOLD;
         end else begin
            case (r_state)
               S_HOLD: begin
                  if (r_hold_cnt == '0) begin
                     r_state     <= S_DECAY;
                     r_decay_cnt <= C_DECAY_LOAD;
                  end else begin
                     r_hold_cnt <= r_hold_cnt - CNT_W'(1);
                  end
               end
               S_DECAY: begin
                  if (r_decay_cnt == '0) begin
                     r_decay_cnt <= C_DECAY_LOAD;
                     r_peak      <= r_peak - 7'd1;
                     if (r_peak == 7'd1) begin
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_decay_cnt <= r_decay_cnt - CNT_W'(1);
                  end
               end
               S_IDLE: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end

         // Clip byte always qualifies (mag 127), so its hold restarts above.
         if (load && w_is_clip) begin
            r_clip <= 1'b1;
         end else if (w_hold_expire) begin
            r_clip <= 1'b0;
         end
      end
   end

   // Per-segment thresholds for the thermometer bar.
   genvar gi;
   generate
      for (gi = 0; gi < LEDS; gi++) begin : g_seg
         assign w_level_next[gi] = ({1'b0, r_peak} > 8'(gi * STEP));
      end
   endgenerate

   // Bar is registered from the peak register, one cycle behind it.
   always_ff @(posedge clkx16 or negedge reset) begin
      if (!reset) begin
         r_level <= '0;
      end else begin
         r_level <= w_level_next;
      end
   end

   // Count rising edges of the framing-error level, saturating at 255.
   always_ff @(posedge clkx16 or negedge reset) begin
      if (!reset) begin
         r_err_d   <= 1'b0;
         r_err_cnt <= 8'd0;
      end else begin
         r_err_d <= error;
         if (error && !r_err_d && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
         end
      end
   end

   assign level   = r_level;
   assign peak    = r_peak;
   assign clip    = r_clip;
   assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_vu_level_meter.sv
// Bench for vu_level_meter with short timers (HOLD 20, DECAY 4, 8 LEDs).
// Reference model: the envelope is a closed-form function of the last
// qualifying load value and the number of cycles elapsed since it.
module tb_vu_level_meter;

   localparam int LEDS  = 8;
   localparam int HOLD  = 20;
   localparam int DECAY = 4;
   localparam int STEP  = 128 / LEDS;
   localparam int K_MAX = 1000000;

   logic            clkx16 = 1'b0;
   logic            reset;
   logic [7:0]      data   = 8'h00;
   logic            load   = 1'b0;
   logic            error  = 1'b0;
   logic [LEDS-1:0] level;
   logic [6:0]      peak;
   logic            clip;
   logic [7:0]      err_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   int m_p0;        // value captured at the last qualifying load
   int m_k;         // clock edges since that load
   int m_clip;
   int m_level;
   int m_err_cnt;
   int m_err_prev;

   vu_level_meter #(
      .LEDS(LEDS), .CNT_W(20), .HOLD_CYCLES(HOLD), .DECAY_CYCLES(DECAY)
   ) dut (
      .clkx16(clkx16), .reset(reset), .data(data), .load(load), .error(error),
      .level(level), .peak(peak), .clip(clip), .err_cnt(err_cnt)
   );

   always #5 clkx16 = ~clkx16;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_value(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_mag(input logic [7:0] d);
      int v;
`ifdef OFFSET_BINARY_EN
      v = int'(d) - 128;
`else
      v = int'($signed(d));
`endif
      if (v < 0) v = -v;
      if (v > 127) v = 127;
      return v;
   endfunction

   function automatic bit ref_is_clip(input logic [7:0] d);
`ifdef OFFSET_BINARY_EN
      return (int'(d) == 0) || (int'(d) == 255);
`else
      return (int'($signed(d)) == 127) || (int'($signed(d)) == -128);
`endif
   endfunction

   // Held for HOLD edges, then loses one unit every DECAY edges.
   function automatic int ref_peak();
      int v;
      if (m_k < HOLD) return m_p0;
      v = m_p0 - (m_k - HOLD) / DECAY;
      return (v < 0) ? 0 : v;
   endfunction

   // Number of lit segments is ceil(peak/STEP).
   function automatic int ref_bar(input int p);
      int n;
      n = (p + STEP - 1) / STEP;
      return (1 << n) - 1;
   endfunction

   task automatic model_reset();
      m_p0 = 0; m_k = K_MAX; m_clip = 0; m_level = 0;
      m_err_cnt = 0; m_err_prev = 0;
   endtask

   // One clock edge: advance the model with the inputs seen at the edge,
   // then compare all outputs shortly after it.
   task automatic step();
      int cur;
      int mag;
      bit took;
      @(posedge clkx16);
      if (!reset) begin
         model_reset();
      end else begin
         cur     = ref_peak();
         m_level = ref_bar(cur);
         if (error && !m_err_prev && m_err_cnt < 255) m_err_cnt++;
         m_err_prev = error;
         took = 1'b0;
         if (load) begin
            mag = ref_mag(data);
            if (mag > cur || (mag == cur && cur != 0)) begin
               took = 1'b1;
               m_p0 = mag;
               m_k  = 0;
               if (ref_is_clip(data)) m_clip = 1;
            end
         end
         if (!took) begin
            if (m_k < K_MAX) m_k++;
            if (m_k == HOLD) m_clip = 0;
         end
      end
      #1;
      check_value("peak", int'(peak), ref_peak());
      check_value("level", int'(level), m_level);
      check_value("clip", int'(clip), m_clip);
      check_value("err_cnt", int'(err_cnt), m_err_cnt);
   endtask

   task automatic do_load(input logic [7:0] d);
      data = d;
      load = 1'b1;
      step();
      $display("load data=%02h mag=%0d -> peak=%0d clip=%0d", d, ref_mag(d), peak, clip);
      load = 1'b0;
      data = 8'($urandom);
   endtask

   initial begin
      int c;
      int n;
      logic [7:0] d;
      model_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      check_value("rst_peak", int'(peak), 0);
      check_value("rst_level", int'(level), 0);
      check_value("rst_clip", int'(clip), 0);
      check_value("rst_errcnt", int'(err_cnt), 0);
      repeat (2) step();
      reset = 1'b1;
      repeat (3) step();

`ifndef OFFSET_BINARY_EN
      // level map
      do_load(8'h40);
      check_value("map_peak64", int'(peak), 64);
      step();
      check_value("map_level64", int'(level), 8'h0F);
      do_load(8'h41);
      check_value("map_peak65", int'(peak), 65);
      step();
      check_value("map_level65", int'(level), 8'h1F);

      // clip / saturation
      do_load(8'h80);
      check_value("clip_peak", int'(peak), 127);
      check_value("clip_set", int'(clip), 1);
      c = 1;
      for (int i = 0; i < 60 && clip; i++) begin
         step();
         if (clip) c++;
      end
      check_value("clip_len", c, HOLD);
      check_value("clip_level", int'(level), 8'hFF);
      repeat (DECAY) step();
      check_value("clip_decay1", int'(peak), 126);
      repeat (DECAY) step();
      check_value("clip_decay2", int'(peak), 125);
      for (int i = 0; i < 700 && peak != 0; i++) step();
      check_value("clip_to_zero", int'(peak), 0);

      // hold restart, ignored smaller load, full decay length
      do_load(8'h40);
      repeat (10) step();
      do_load(8'hC0);
      check_value("refresh_peak", int'(peak), 64);
      do_load(8'h10);
      check_value("small_ignored", int'(peak), 64);
      repeat (15) step();
      check_value("hold_restart", int'(peak), 64);
      n = 16;
      while (peak != 0 && n < 400) begin
         step();
         n++;
      end
      check_value("hold_decay_len", n, HOLD + 64 * DECAY);
      step();
      check_value("idle_level", int'(level), 0);

      // collision with a decay step
      do_load(8'h30);
      repeat (HOLD + DECAY - 1) step();
      check_value("coll_before", int'(peak), 48);
      do_load(8'h30);
      check_value("coll_peak", int'(peak), 48);
      repeat (HOLD + DECAY - 1) step();
      check_value("coll_held", int'(peak), 48);
      step();
      check_value("coll_decay", int'(peak), 47);

      // asynchronous reset while decaying from 50
      do_load(8'h32);
      repeat (HOLD + 2) step();
      check_value("pre_rst_peak", int'(peak), 50);
      reset = 1'b0;
      model_reset();
      #1;
      check_value("arst_peak", int'(peak), 0);
      check_value("arst_level", int'(level), 0);
      check_value("arst_clip", int'(clip), 0);
      repeat (2) step();
      reset = 1'b1;
      repeat (5) step();
      check_value("post_rst_idle", int'(peak), 0);
      do_load(8'h00);
      check_value("zero_load_idle", int'(peak), 0);
`else
      do_load(8'h80);
      check_value("ob_silence", int'(peak), 0);
      do_load(8'hC0);
      check_value("ob_peak64", int'(peak), 64);
      do_load(8'h00);
      check_value("ob_peak127", int'(peak), 127);
      check_value("ob_clip", int'(clip), 1);
`endif

      // framing-error edge counting
      error = 1'b1; repeat (3) step();
      error = 1'b0; repeat (2) step();
      error = 1'b1; step();
      error = 1'b0; step();
      check_value("err_two_edges", int'(err_cnt), 2);
      for (int i = 0; i < 300; i++) begin
         error = 1'b1; step();
         error = 1'b0; step();
      end
      check_value("err_saturate", int'(err_cnt), 255);

      // randomized traffic from a fresh reset
      reset = 1'b0;
      model_reset();
      step();
      reset = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) error = ~error;
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 7))
               0: d = 8'h7F;
               1: d = 8'h80;
               2: d = 8'h00;
               3: d = 8'hFF;
               4: d = 8'(ref_peak());
               5: d = 8'(-ref_peak());
               default: d = 8'($urandom);
            endcase
`ifdef OFFSET_BINARY_EN
            if (d == 8'(ref_peak())) d = 8'(ref_peak() + 128);
`endif
            do_load(d);
         end else begin
            step();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vu_level_meter.md
Name: vu_level_meter

Overview:
- Sits directly downstream of the serial byte receiver, on the same clkx16 domain.
- Each received byte is treated as one audio sample. The block computes its magnitude and tracks a peak-hold/decay envelope.
- It drives a thermometer-coded LED bar plus a clip indicator, and counts framing-error events reported by the receiver.

Parameters:
- LEDS, 8, number of bar segments; power of two, 2..128; STEP = 128/LEDS.
- CNT_W, 20, width of the hold and decay timers.
- HOLD_CYCLES, 921600, clkx16 cycles the peak is held after a refresh (~0.5 s at 16x115200).
- DECAY_CYCLES, 14400, clkx16 cycles per 1-unit peak decrement.

Ports:
- clkx16  input  1  block clock (16x baud clock shared with the receiver).
- reset  input  1  asynchronous, active-low reset.
- data  input  8  received byte; valid only in the cycle load=1.
- load  input  1  single-cycle strobe: data holds a good byte.
- error  input  1  receiver framing error; level signal, may stay high many cycles.
- level  output  LEDS  thermometer bar; bit i = segment i.
- peak  output  7  current envelope value, 0..127.
- clip  output  1  clip indicator.
- err_cnt  output  8  saturating count of error rising edges.

Behaviour:
- Reset (reset=0, asynchronous):
  - level=0, peak=0, clip=0, err_cnt=0.
  - Timers cleared, state=IDLE, error edge-detect register=0.
  - Applies mid-operation with no pending update surviving.
- Magnitude, combinational from data:
  - Two's complement: mag = |data|.
  - -128 (0x80) saturates to 127, so mag is always 7 bits, 0..127.
  - A sample is clipping when the raw byte is 0x7F or 0x80.
- State machine on the peak register: IDLE, HOLD, DECAY.
  - load=1 and mag > peak, any state: peak <= mag; hold timer <= HOLD_CYCLES-1; state <= HOLD.
  - load=1 and mag == peak and peak != 0: hold timer reloaded; state <= HOLD; peak unchanged.
  - load=1 and mag < peak: ignored.
  - HOLD: timer decrements each cycle. When the timer is 0 and there is no refresh: state <= DECAY, decay timer <= DECAY_CYCLES-1.
  - DECAY: decay timer decrements each cycle. At 0 it reloads and peak decrements by 1. When peak reaches 0: state <= IDLE.
  - IDLE: peak=0; waits for a load with mag > 0.
  - A load that qualifies for update or refresh in the same cycle as a decay step or hold expiry wins; the decay step is discarded.
  - A load with mag=0 in IDLE has no effect.
- Latency:
  - peak updates 1 cycle after the load cycle.
  - level is registered from peak: 1 further cycle.
  - level bit i = 1 iff peak > i*STEP.
- clip:
  - Set 1 cycle after any load of a clipping byte; the hold timer is reloaded at the same time.
  - Cleared when the hold timer expires (HOLD->DECAY transition).
  - A new clipping byte while clip=1 keeps clip high and restarts the hold.
- err_cnt:
  - Increments on each 0->1 transition of error, sampled on clkx16.
  - Saturates at 255; no wrap.
- load while error=1 is processed normally; the two inputs are independent.

Optional Feature:
- Macro OFFSET_BINARY_EN.
- Defined: data is offset-binary (0x80 = silence); mag = |data - 128|, with 0x00 saturating to 127. Clipping bytes are 0x00 and 0xFF.
- Undefined: two's-complement behaviour as above.

Test Plan (LEDS=8, HOLD_CYCLES=20, DECAY_CYCLES=4, two's complement):
- Reset: drive reset low during DECAY with peak=50 -> all outputs 0 immediately; after release, idle until next load.
- Level map: load data=0x40 -> peak=64 the next cycle, level=8'b0000_1111 one cycle later. Then data=0x41 -> peak=65, level=8'b0001_1111.
- Clip/saturation: data=0x80 -> peak=127, level=8'hFF, clip=1 for exactly 20 cycles. Then clip=0 and peak decrements by 1 every 4 cycles.
- Hold/decay: after 0x40 with no further loads -> peak=64 held 20 cycles, then 63,62,... each 4 cycles. Reaches 0 after 256 decay cycles (level 0, state IDLE).
  - Load 0xC0 (mag 64) at cycle 10 of hold -> hold restarts.
  - Load 0x10 -> no change.
- Collision: load data=0x30 in the same cycle as a decay step with peak=48 -> hold refreshed, peak stays 48 (not 47).
- Errors: error high 3 cycles, low 2, high 1 -> err_cnt=2. Apply 300 edges -> err_cnt=255.
- With OFFSET_BINARY_EN: data=0x80 -> peak 0, no state change; data=0xC0 -> peak=64; data=0x00 -> peak=127, clip=1.
